// File: rtl/deserializer_pkg.sv
// Shared constants and helpers for the serial-link deserializer.
package deserializer_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int MIN_BITS_DEF = 3;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Shift that moves an nbits-long right-aligned burst up to the MSB end of a word.
  function automatic int unsigned lalign_shift(input int unsigned width, input int unsigned nbits);
    return width - nbits;
  endfunction

endpackage

// File: rtl/deser_shift_cnt.sv
// Serial-in shift register and bit counter; counter wraps to 0 on the bit that completes a word.
// Single-cycle update, no flow control of its own.
module deser_shift_cnt
  import deserializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              shift_en,
  input  logic              ser_bit,
  input  logic              clr,
  output logic [DATA_W-1:0] shreg,
  output logic [DATA_W-1:0] shreg_nxt,
  output logic [MOD_W-1:0]  cnt,
  output logic              last_bit
);

  assign shreg_nxt = {shreg[DATA_W-2:0], ser_bit};
  // The bit currently being shifted in is the final bit of a full word.
  assign last_bit  = (cnt == MOD_W'(DATA_W - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= shreg_nxt;
      cnt   <= last_bit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/deserializer.sv
// deserializer: MSB-first serial bits to left-aligned words; 1-cycle latency, no backpressure.
// Defining DESERIALIZER_RUNT_ERR_EN adds runt_err_o, pulsed when a too-short burst is dropped.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MOD_W    = $clog2(DATA_W),
  parameter int MIN_BITS = MIN_BITS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
`ifdef DESERIALIZER_RUNT_ERR_EN
  ,
  output logic              runt_err_o
`endif
);

  logic [0:0]        state_q;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [MOD_W-1:0]  cnt;
  logic              last_bit;
  logic              burst_end;
  logic              word_done;
  logic              keep_partial;
  logic [MOD_W-1:0]  shamt;

  assign burst_end    = (state_q == ST_COLLECT) && !ser_data_val_i;
  assign word_done    = (state_q == ST_COLLECT) && ser_data_val_i && last_bit;
  assign keep_partial = (cnt >= MOD_W'(MIN_BITS));
  assign shamt        = MOD_W'(lalign_shift(DATA_W, 32'(cnt)));
  assign busy_o       = (state_q == ST_COLLECT);

  deser_shift_cnt #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W)
  ) u_shift_cnt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .shift_en  (ser_data_val_i),
    .ser_bit   (ser_data_i),
    .clr       (burst_end),
    .shreg     (shreg),
    .shreg_nxt (shreg_nxt),
    .cnt       (cnt),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= ST_IDLE;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
`ifdef DESERIALIZER_RUNT_ERR_EN
      runt_err_o       <= 1'b0;
`endif
    end else begin
      deser_data_val_o <= 1'b0;
`ifdef DESERIALIZER_RUNT_ERR_EN
      runt_err_o       <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (ser_data_val_i) state_q <= ST_COLLECT;
        end
        default: begin
          // A full word captures the incoming bit too, so the next word can start without a gap.
          if (word_done) begin
            deser_data_o     <= shreg_nxt;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b1;
            state_q          <= ST_IDLE;
          end else if (burst_end) begin
            if (keep_partial) begin
              deser_data_o     <= shreg << shamt;
              deser_data_mod_o <= cnt;
              deser_data_val_o <= 1'b1;
            end
`ifdef DESERIALIZER_RUNT_ERR_EN
            else begin
              runt_err_o <= 1'b1;
            end
`endif
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: a bit-level reference model queues expected words, a monitor checks each pulse.
module tb_deserializer;

  localparam int DATA_W   = 16;
  localparam int MOD_W    = 4;
  localparam int MIN_BITS = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
    int                cyc;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              ser_data_i = 1'b0;
  logic              ser_data_val_i = 1'b0;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;
`ifdef DESERIALIZER_RUNT_ERR_EN
  logic              runt_err_o;
  int                runt_q[$];
`endif

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] m_shreg = '0;
  int                m_cnt = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  deserializer #(
    .DATA_W   (DATA_W),
    .MOD_W    (MOD_W),
    .MIN_BITS (MIN_BITS)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
`ifdef DESERIALIZER_RUNT_ERR_EN
    ,
    .runt_err_o       (runt_err_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Drive one cycle of the link, update the reference model, then check busy just after the edge.
  task automatic drive_cycle(input logic v, input logic b);
    exp_t e;
    ser_data_val_i = v;
    ser_data_i     = b;
    if (v) begin
      m_shreg = {m_shreg[DATA_W-2:0], b};
      m_cnt++;
      if (m_cnt == DATA_W) begin
        e.data = m_shreg;
        e.mod  = '0;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        m_cnt   = 0;
        m_shreg = '0;
      end
    end else if (m_cnt != 0) begin
      if (m_cnt >= MIN_BITS) begin
        e.data = m_shreg << (DATA_W - m_cnt);
        e.mod  = 4'(m_cnt);
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
`ifdef DESERIALIZER_RUNT_ERR_EN
      else runt_q.push_back(cyc + 1);
`endif
      m_cnt   = 0;
      m_shreg = '0;
    end
    @(posedge clk_i);
    #1;
    check("busy", 32'(busy_o), 32'(m_cnt != 0));
  endtask

  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, w[n-1-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (deser_data_val_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data", 32'(deser_data_o), 32'(mon_e.data));
        check("mod", 32'(deser_data_mod_o), 32'(mon_e.mod));
        check("latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

`ifdef DESERIALIZER_RUNT_ERR_EN
  always @(negedge clk_i) begin
    int want_cyc;
    if (runt_err_o) begin
      if (runt_q.size() == 0) begin
        check("unexpected_runt", 32'd1, 32'd0);
      end else begin
        want_cyc = runt_q.pop_front();
        check("runt_latency", 32'(cyc), 32'(want_cyc));
      end
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data", 32'(deser_data_o), 32'h0);
    check("rst_mod", 32'(deser_data_mod_o), 32'h0);
    check("rst_val", 32'(deser_data_val_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
`ifdef DESERIALIZER_RUNT_ERR_EN
    check("rst_runt", 32'(runt_err_o), 32'h0);
`endif
    rst_n_i = 1'b1;
    idle(2);

    send_bits(64'hA5C3, 16);
    idle(3);
    check("hold_a5c3", 32'(deser_data_o), 32'hA5C3);

    send_bits({32'h0, 16'h1234, 16'hFFFF}, 32);
    idle(2);
    check("hold_ffff", 32'(deser_data_o), 32'hFFFF);

    send_bits(64'b10110, 5);
    idle(2);
    check("partial_data", 32'(deser_data_o), 32'hB000);
    check("partial_mod", 32'(deser_data_mod_o), 32'd5);

    send_bits(64'b11, 2);
    idle(2);
    check("runt_hold_data", 32'(deser_data_o), 32'hB000);

    send_bits(64'h1AB, 9);
    rst_n_i = 1'b0;
    ser_data_val_i = 1'b0;
    m_cnt   = 0;
    m_shreg = '0;
    #1;
    check("midrst_data", 32'(deser_data_o), 32'h0);
    check("midrst_mod", 32'(deser_data_mod_o), 32'h0);
    check("midrst_busy", 32'(busy_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    send_bits(64'h0F0F, 16);
    idle(2);
    check("after_rst_data", 32'(deser_data_o), 32'h0F0F);

    for (int k = 0; k < 25; k++) begin
      send_bits({$urandom, $urandom}, $urandom_range(1, 40));
      idle($urandom_range(1, 4));
    end

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef DESERIALIZER_RUNT_ERR_EN
    check("runt_queue_drained", 32'(runt_q.size()), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive side of the team's serial bit link: collects an MSB-first stream qualified by a valid strobe back into parallel words.
- A full 16-bit word is emitted when complete.
- A shorter burst, ended by the valid strobe dropping, is emitted as a partial word with a bit count.
- Sits directly downstream of the serializer on the same link; output feeds word-level consumers (FIFO, checker).

Parameters:
- DATA_W, 16, parallel word width and maximum burst length in bits.
- MOD_W, $clog2(DATA_W), width of the bit-count output.
- MIN_BITS, 3, shortest partial burst accepted; shorter bursts are discarded (runts).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- ser_data_i  input  1  serial data bit, MSB of word first.
- ser_data_val_i  input  1  ser_data_i valid this cycle.
- deser_data_o  output  DATA_W  assembled word, left-aligned; unused low bits 0.
- deser_data_mod_o  output  MOD_W  valid bit count; 0 means a full DATA_W bits.
- deser_data_val_o  output  1  one-cycle pulse; deser_data_o and deser_data_mod_o are valid.
- busy_o  output  1  high while a burst is partially assembled.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; shift register and bit counter 0.
  - deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0.
- States:
  - IDLE: no bits held.
  - COLLECT: 1..DATA_W-1 bits held.
- IDLE, val=1: shift in bit (shreg <= {shreg[DATA_W-2:0], bit}), cnt=1, go to COLLECT.
- COLLECT, val=1: shift in bit, cnt+1.
  - If this is bit DATA_W: next cycle deser_data_val_o=1, deser_data_o=shreg, deser_data_mod_o=0; go to IDLE, cnt=0.
- COLLECT, val=0 (burst end):
  - cnt>=MIN_BITS: next cycle deser_data_val_o=1, deser_data_o = shreg << (DATA_W-cnt) (left-aligned, low bits 0), deser_data_mod_o=cnt.
  - cnt<MIN_BITS: discard as runt, no output pulse.
  - Either way: go to IDLE, clear cnt and shreg.
- Latency: 1 cycle from the last-bit edge (full word) or the first val=0 edge (partial) to the deser_data_val_o pulse.
- Back-to-back: bit DATA_W+1 arriving the cycle after bit DATA_W starts a new word with no gap and no loss; the output pulse and the new shift run in parallel.
- A continuous stream of k*DATA_W valid bits yields exactly k full words.
- busy_o is registered: 1 when cnt!=0 after the edge.
- deser_data_o and deser_data_mod_o hold their last value between pulses; deser_data_val_o lasts exactly one cycle.
- No backpressure: consumers must accept every pulse.
- Reset mid-burst: partial bits are dropped, no pulse, outputs return to reset values immediately.
- A single-cycle val glitch (1 bit, then val=0) is a runt and is discarded.

Optional Feature:
- DESERIALIZER_RUNT_ERR_EN
- Defined:
  - Adds output port runt_err_o (1 bit, reset 0).
  - Pulses one cycle, aligned to where deser_data_val_o would have pulsed, whenever a burst of 1..MIN_BITS-1 bits is discarded.
- Undefined: port absent; runts are dropped silently. Core behaviour is identical in both builds.

Decomposition:
- Package deserializer_pkg:
  - state enum (IDLE, COLLECT)
  - DATA_W default
  - MIN_BITS default
  - function computing left-align shift
- One natural sub-module: deser_shift_cnt (shift register plus bit counter with full/last-bit flags). The FSM and output register stay in the top module.

Test Plan:
- Reset then 16 valid bits of 16'hA5C3 MSB-first -> one pulse, data=16'hA5C3, mod=0, busy_o high for cycles 1..15 only.
- 32 continuous bits 16'h1234 then 16'hFFFF -> two pulses 16 cycles apart, data 16'h1234 then 16'hFFFF, mod=0 both.
- 5 bits 1,0,1,1,0 then val=0 -> one pulse, data=16'hB000, mod=5.
- 2 bits then val=0 -> no pulse, busy_o back to 0. With DESERIALIZER_RUNT_ERR_EN: runt_err_o pulses once.
- rst_n_i low after 9 bits of a burst, released, then 16 bits of 16'h0F0F -> only 16'h0F0F delivered, no stale bits.
- Random bursts of length 1..40 with random gaps, checked against the serializer reference model -> every burst >=MIN_BITS reconstructed exactly, correct count, 1-cycle latency.
